// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined RISC-V immediate generator. The instruction word is decoded
// combinationally into an XLEN-wide immediate (RV32I/RV64I formats) and the
// result is registered into a two-deep output stage (main + skid register)
// with a valid/ready handshake. in_ready comes straight from a flop, so the
// upstream ready path is not combinationally coupled to out_ready.
//
// Parameters
//   XLEN   datapath width, 32 or 64
//   TAG_W  width of the sideband tag travelling with each entry
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   flush       synchronous flush, drops every held entry (highest priority)
//   in_valid    upstream entry valid
//   in_ready    block can accept an entry this cycle (registered, = !skid_valid)
//   in_instr    raw 32-bit instruction word
//   in_imm_sel  immediate format select
//   in_tag      sideband tag
//   out_valid   output entry valid
//   out_ready   downstream accepts the output entry
//   out_imm     decoded immediate
//   out_tag     tag of the output entry
//   out_err     entry was decoded with an illegal format select
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef enum logic [2:0] {
    SEL_I     = 3'b000,
    SEL_S     = 3'b001,
    SEL_B     = 3'b010,
    SEL_J     = 3'b011,
    SEL_U     = 3'b100,
    SEL_SHAMT = 3'b101,
    SEL_ZIMM  = 3'b110,
    SEL_ILL   = 3'b111
  } imm_sel_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode. Every format is built at 64 bits with sign extension
  // already applied, then truncated to XLEN; this keeps one expression per
  // format that is correct for both widths.
  // ---------------------------------------------------------------------------
  logic [31:0] ins;
  logic        sgn;
  logic [63:0] imm_wide;
  entry_t      dec;

  assign ins = in_instr;
  assign sgn = in_instr[31];

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    imm_wide = '0;
    dec      = '0;
    dec.tag  = in_tag;
    case (imm_sel_e'(in_imm_sel))
      SEL_I:     imm_wide = {{52{sgn}}, ins[31:20]};
      SEL_S:     imm_wide = {{52{sgn}}, ins[31:25], ins[11:7]};
      SEL_B:     imm_wide = {{51{sgn}}, sgn, ins[7], ins[30:25], ins[11:8], 1'b0};
      SEL_J:     imm_wide = {{43{sgn}}, sgn, ins[19:12], ins[20], ins[30:21], 1'b0};
      // Sign extension from bit 31 only shows up when XLEN=64.
      SEL_U:     imm_wide = {{32{sgn}}, ins[31:12], 12'b0};
      // RV64 shift amounts carry a sixth bit.
      SEL_SHAMT: imm_wide = (XLEN == 64) ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
      SEL_ZIMM:  imm_wide = {59'b0, ins[19:15]};
      default:   dec.err  = 1'b1;
    endcase
    dec.imm = imm_wide[XLEN-1:0];
  end

  // ---------------------------------------------------------------------------
  // Output stage: main register drives the outputs, skid register catches the
  // one entry that can arrive after downstream stalls (in_ready is registered,
  // so upstream only learns about the stall a cycle late).
  //
  // Invariant: skid_valid implies main_valid, so FIFO order is main then skid.
  // ---------------------------------------------------------------------------
  entry_t main_q, skid_q;
  logic   main_valid, skid_valid;
  logic   accept, main_free;

  // in_ready is high exactly when skid is empty, so an accepted entry always
  // has a place to go.
  assign accept    = in_valid && !skid_valid;
  assign main_free = !main_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the data registers are reset too because the outputs they drive
      // must read zero while in reset.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      // Flush wins over accept and drain; the data is left as-is since it is
      // qualified by the valids.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // Oldest waiting entry moves up; no accept is possible this cycle.
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        // Empty or draining main takes the new entry directly.
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the entry in skid; in_ready drops next cycle.
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_imm   = main_q.imm;
  assign out_tag   = main_q.tag;
  assign out_err   = main_q.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Drives one XLEN=32 and one XLEN=64 instance with identical stimulus. A
// reference decoder computes expected immediates when an entry is accepted and
// pushes them to a scoreboard queue; they are popped and compared when the
// output handshake completes. Occupancy of the queue also predicts in_ready
// and out_valid each cycle.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready32, out_valid32, out_err32;
  logic [31:0]      out_imm32;
  logic [TAG_W-1:0] out_tag32;
  logic             in_ready64, out_valid64, out_err64;
  logic [63:0]      out_imm64;
  logic [TAG_W-1:0] out_tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_err(out_err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_err(out_err64)
  );

  typedef struct {
    logic [31:0]      imm32;
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference decoder: places each field at the top of a 64-bit word and
  // arithmetic-shifts it down into position.
  function automatic logic [63:0] ref_imm(input logic [31:0] i,
                                          input logic [2:0]  s,
                                          input bit          x64);
    logic signed [63:0] v;
    case (s)
      3'd0:    v = $signed({i[31:20], 52'b0}) >>> 52;
      3'd1:    v = $signed({i[31:25], i[11:7], 52'b0}) >>> 52;
      3'd2:    v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 51'b0}) >>> 51;
      3'd3:    v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 43'b0}) >>> 43;
      3'd4:    v = $signed({i[31:12], 44'b0}) >>> 32;
      3'd5:    v = x64 ? 64'(i[25:20]) : 64'(i[24:20]);
      3'd6:    v = 64'(i[19:15]);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit v, input logic [31:0] ins, input logic [2:0] s,
                     input logic [TAG_W-1:0] t);
    in_valid = v;
    if (v) begin
      in_instr   = ins;
      in_imm_sel = s;
      in_tag     = t;
    end else begin
      in_instr   = 'x;
      in_imm_sel = 'x;
      in_tag     = 'x;
    end
  endtask

  // Called just after a falling edge with inputs already driven: checks the
  // current outputs against the scoreboard, updates it for the coming rising
  // edge, then advances to the next falling edge.
  task automatic step();
    exp_t   e;
    logic   rdy;
    logic [63:0] w;
    rdy = (sb.size() < 2);
    chk("in_ready32",  in_ready32,  rdy);
    chk("in_ready64",  in_ready64,  rdy);
    chk("out_valid32", out_valid32, sb.size() > 0);
    chk("out_valid64", out_valid64, sb.size() > 0);
    if (flush) begin
      sb.delete();
    end else begin
      if (out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("imm32", out_imm32, e.imm32);
        chk("imm64", out_imm64, e.imm64);
        chk("tag32", out_tag32, e.tag);
        chk("tag64", out_tag64, e.tag);
        chk("err32", out_err32, e.err);
        chk("err64", out_err64, e.err);
      end
      if (in_valid && rdy) begin
        w       = ref_imm(in_instr, in_imm_sel, 1'b0);
        e.imm32 = w[31:0];
        e.imm64 = ref_imm(in_instr, in_imm_sel, 1'b1);
        e.tag   = in_tag;
        e.err   = (in_imm_sel == 3'b111);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] t32_instr [5] = '{32'hFFF00093, 32'h0020A423, 32'h80000063,
                                 32'h0080006F, 32'h123450B7};
  logic [31:0] t32_exp   [5] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFF000,
                                 32'h00000008, 32'h12345000};
  logic [2:0]  t64_sel   [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
  logic [31:0] t64_instr [4] = '{32'hFFF00093, 32'h800000B7, 32'h03F09093, 32'h000FD073};
  logic [63:0] t64_exp   [4] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000,
                                 64'h000000000000003F, 64'h000000000000001F};

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drv(0, '0, '0, '0);
    #1;
    chk("rst_valid", out_valid32, 0);
    chk("rst_imm32", out_imm32, 0);
    chk("rst_imm64", out_imm64, 0);
    chk("rst_tag",   out_tag32, 0);
    chk("rst_err",   out_err32, 0);
    chk("rst_ready", in_ready32, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // RV32 formats, one at a time; 1-cycle latency.
    for (int k = 0; k < 5; k++) begin
      drv(1, t32_instr[k], 3'(k), 5'(k + 1));
      step();
      drv(0, '0, '0, '0);
      chk("lat32_valid", out_valid32, 1);
      chk("fmt32_imm",   out_imm32,   t32_exp[k]);
      chk("fmt32_err",   out_err32,   0);
      step();
    end

    // RV64-specific extensions.
    for (int k = 0; k < 4; k++) begin
      drv(1, t64_instr[k], t64_sel[k], 5'(k + 8));
      step();
      drv(0, '0, '0, '0);
      chk("fmt64_imm", out_imm64, t64_exp[k]);
      step();
    end

    // Back-pressure: 1 in main, 2 in skid, 3 held upstream.
    out_ready = 1'b0;
    drv(1, 32'hFFF00093, 3'd0, 5'd1); step();
    drv(1, 32'h0020A423, 3'd1, 5'd2); step();
    drv(1, 32'h123450B7, 3'd4, 5'd3);
    chk("bp_ready_low", in_ready32, 0);
    chk("bp_main_tag",  out_tag32,  1);
    step();
    chk("bp_hold_tag",  out_tag32,  1);
    step();
    out_ready = 1'b1;
    step();                 // tag 1 leaves, skid moves up
    step();                 // tag 2 leaves, tag 3 accepted
    drv(0, '0, '0, '0);
    step();                 // tag 3 leaves
    chk("bp_empty", out_valid32, 0);

    // Full throughput.
    for (int k = 0; k < 16; k++) begin
      drv(1, $urandom(), 3'($urandom_range(0, 6)), 5'(k));
      step();
    end
    drv(0, '0, '0, '0);
    step();

    // Illegal select, then a legal entry.
    drv(1, $urandom(), 3'd7, 5'h15); step();
    drv(1, 32'hFFF00093, 3'd0, 5'h16);
    chk("ill_err", out_err32, 1);
    chk("ill_imm", out_imm64, 0);
    chk("ill_tag", out_tag32, 5'h15);
    step();
    drv(0, '0, '0, '0);
    chk("legal_err", out_err32, 0);
    step();

    // Flush with main and skid full and a new entry presented.
    out_ready = 1'b0;
    drv(1, 32'h0080006F, 3'd3, 5'd4); step();
    drv(1, 32'h80000063, 3'd2, 5'd5); step();
    drv(1, 32'hFFF00093, 3'd0, 5'd9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drv(0, '0, '0, '0);
    chk("flush_valid", out_valid32, 0);
    chk("flush_ready", in_ready32,  1);
    step();

    // Fill again, then asynchronous reset mid-cycle.
    drv(1, 32'h0080006F, 3'd3, 5'd6); step();
    drv(1, 32'h80000063, 3'd2, 5'd7); step();
    drv(0, '0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid32, 0);
    chk("arst_imm",   out_imm64,   0);
    chk("arst_tag",   out_tag32,   0);
    chk("arst_ready", in_ready32,  1);
    sb.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drv(1, 32'h123450B7, 3'd4, 5'd11); step();
    drv(0, '0, '0, '0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
